// File: rtl/tdm_pkg.sv
// Shared TDM frame-format definitions used by both the receive demux and the
// transmit mux so the two ends agree on slot count, slot width and encoding.
//   State encodings : ST_HUNT, ST_RECEIVE
//   Defaults        : TDM_CHANNELS, TDM_SLOT_W
//   Helpers         : frame_bits(), cnt_width()
package tdm_pkg;

  localparam int unsigned TDM_CHANNELS = 4;
  localparam int unsigned TDM_SLOT_W   = 8;

  localparam logic [0:0] ST_HUNT    = 1'b0;
  localparam logic [0:0] ST_RECEIVE = 1'b1;

  // Total serial bits in one frame.
  function automatic int unsigned frame_bits(input int unsigned channels,
                                             input int unsigned slot_w);
    return channels * slot_w;
  endfunction

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Bit-within-slot and slot-within-frame position tracker for the TDM receiver.
//   clock, reset      : clock and async active-high reset
//   i_clear           : return both counters to zero
//   i_load_one        : position after a sync edge (bit 1 of slot 0)
//   i_advance         : one more bit sampled inside a frame
//   o_slot_cnt        : current slot index
//   o_slot_done_c     : this advance completes a slot
//   o_frame_done_c    : this advance completes the last slot of the frame
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int unsigned CHANNELS = TDM_CHANNELS,
  parameter int unsigned SLOT_W   = TDM_SLOT_W
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             i_clear,
  input  logic                             i_load_one,
  input  logic                             i_advance,
  output logic [cnt_width(CHANNELS)-1:0]   o_slot_cnt,
  output logic                             o_slot_done_c,
  output logic                             o_frame_done_c
);

  localparam int unsigned BIT_CW  = cnt_width(SLOT_W);
  localparam int unsigned SLOT_CW = cnt_width(CHANNELS);

  logic [BIT_CW-1:0]  r_bit_cnt;
  logic [SLOT_CW-1:0] r_slot_cnt;
  logic               w_bit_last;
  logic               w_slot_last;

  assign w_bit_last  = (r_bit_cnt == BIT_CW'(SLOT_W - 1));
  assign w_slot_last = (r_slot_cnt == SLOT_CW'(CHANNELS - 1));

  // Counter update: clear beats load beats advance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bit_cnt  <= '0;
      r_slot_cnt <= '0;
    end else if (i_clear) begin
      r_bit_cnt  <= '0;
      r_slot_cnt <= '0;
    end else if (i_load_one) begin
      r_bit_cnt  <= BIT_CW'(1);
      r_slot_cnt <= '0;
    end else if (i_advance) begin
      if (w_bit_last) begin
        r_bit_cnt  <= '0;
        r_slot_cnt <= w_slot_last ? '0 : r_slot_cnt + SLOT_CW'(1);
      end else begin
        r_bit_cnt <= r_bit_cnt + BIT_CW'(1);
      end
    end
  end

  assign o_slot_cnt     = r_slot_cnt;
  assign o_slot_done_c  = i_advance && w_bit_last;
  assign o_frame_done_c = i_advance && w_bit_last && w_slot_last;

endmodule

// File: rtl/tdm_demux.sv
// Receive side of the shared-line TDM link: hunts for frame_sync, shifts in a
// frame MSB first and publishes every channel at once when the frame is whole.
//   clock, reset : clock and async active-high reset
//   serial_in    : shared-line data bit
//   frame_sync   : marks bit 0 of slot 0
//   ch_data      : last complete frame, channel i at [i*SLOT_W +: SLOT_W]
//   frame_valid  : one-cycle pulse, ch_data just updated
//   sync_error   : one-cycle pulse, sync seen mid-frame
//   busy         : receiving a frame
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned CHANNELS = TDM_CHANNELS,
  parameter int unsigned SLOT_W   = TDM_SLOT_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         serial_in,
  input  logic                         frame_sync,
  output logic [CHANNELS*SLOT_W-1:0]   ch_data,
  output logic                         frame_valid,
  output logic                         sync_error,
  output logic                         busy
);

  localparam int unsigned FRAME_BITS = frame_bits(CHANNELS, SLOT_W);
  localparam int unsigned SLOT_CW    = cnt_width(CHANNELS);
  localparam int unsigned SHADOW_W   = FRAME_BITS - SLOT_W;

  logic [0:0]            r_state;
  logic [0:0]            w_state_next;
  logic [SLOT_W-1:0]     r_shift;
  // Only slots 0..CHANNELS-2 are parked; the last slot goes straight to ch_data.
  logic [SHADOW_W-1:0]   r_shadow;
  logic [FRAME_BITS-1:0] r_ch_data;
  logic                  r_frame_valid;
  logic                  r_sync_error;
  logic                  r_busy;

  logic                  w_in_receive;
  logic                  w_advance;
  logic                  w_slot_done;
  logic                  w_frame_done;
  logic [SLOT_CW-1:0]    w_slot_cnt;
  logic [SLOT_W-1:0]     w_slot_word;
  logic [FRAME_BITS-1:0] w_frame_word;

  assign w_in_receive = (r_state == ST_RECEIVE);
  assign w_advance    = w_in_receive && !frame_sync;
  assign w_slot_word  = {r_shift[SLOT_W-2:0], serial_in};
  assign w_frame_word = {w_slot_word, r_shadow};

  tdm_slot_counter #(
    .CHANNELS (CHANNELS),
    .SLOT_W   (SLOT_W)
  ) u_slot_counter (
    .clock          (clock),
    .reset          (reset),
    .i_clear        (w_frame_done),
    .i_load_one     (frame_sync),
    .i_advance      (w_advance),
    .o_slot_cnt     (w_slot_cnt),
    .o_slot_done_c  (w_slot_done),
    .o_frame_done_c (w_frame_done)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: any sync (re)starts a frame, completion returns to hunting.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_HUNT:    if (frame_sync) w_state_next = ST_RECEIVE;
      ST_RECEIVE: if (w_frame_done) w_state_next = ST_HUNT;
      default:    w_state_next = ST_HUNT;
    endcase
  end

  // Slot shift register; a sync bit discards whatever was partially shifted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
    end else if (frame_sync) begin
      r_shift <= SLOT_W'(serial_in);
    end else if (w_in_receive) begin
      r_shift <= w_slot_word;
    end
  end

  // Park completed slots until the frame is whole.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shadow <= '0;
    end else if (w_slot_done) begin
      for (int unsigned i = 0; i < CHANNELS - 1; i++) begin
        if (w_slot_cnt == SLOT_CW'(i)) begin
          r_shadow[i*SLOT_W +: SLOT_W] <= w_slot_word;
        end
      end
    end
  end

  // Published frame and status strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ch_data     <= '0;
      r_frame_valid <= 1'b0;
      r_sync_error  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      if (w_frame_done) begin
        r_ch_data <= w_frame_word;
      end
      r_frame_valid <= w_frame_done;
      r_sync_error  <= w_in_receive && frame_sync;
      r_busy        <= (w_state_next == ST_RECEIVE);
    end
  end

  assign ch_data     = r_ch_data;
  assign frame_valid = r_frame_valid;
  assign sync_error  = r_sync_error;
  assign busy        = r_busy;

endmodule
